req_fifo: RTL and testbench

- Synchronous first-word-fall-through (FWFT) FIFO that queues memory-miss requests between a cache and the main-memory arbiter.
- One instance per cache (I$ and D$). Each is sized to hold one outstanding request per hardware thread.
- The arbiter samples the head entry combinationally through `rdata`/`valid` and pops it in the same cycle it forwards the request.

---
 rtl/req_fifo.sv | 95 +++++++++
 tb/tb_req_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/req_fifo.sv
// req_fifo: first-word-fall-through queue of memory-miss requests between
// a cache and the main-memory arbiter, one slot per hardware thread.
module req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic empty;
    logic is_full;
    logic do_pop;
    logic do_push;

    assign empty   = (count_q == '0);
    assign is_full = (count_q == CNT_FULL);

    always_comb begin
        do_pop      = pop & ~empty;
        do_push     = push & (~is_full | do_pop);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = push & is_full & ~pop;
        underflow_d = pop & empty;

        // Pointers wrap explicitly so DEPTH need not be a power of two.
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; valid gates its use.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign valid     = ~empty;
    assign full      = is_full;
    assign count     = count_q;
    assign rdata     = empty ? '0 : mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_req_fifo.sv
// tb_req_fifo: vector table, directed corner sequences and random traffic
// against a queue-based reference for req_fifo (WIDTH=8, DEPTH=4).
module tb_req_fifo;

    localparam int W = 8;
    localparam int D = 4;
    localparam int CW = $clog2(D + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          pop = 1'b0;
    logic [W-1:0]  rdata;
    logic          valid;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic         m_ovf;
    logic         m_unf;

    req_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .push(push), .wdata(wdata),
        .pop(pop), .rdata(rdata), .valid(valid), .full(full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         push;
        logic         pop;
        logic [W-1:0] wdata;
        int           cnt;
        logic         vld;
        logic         ful;
        logic [W-1:0] rd;
        logic         ovf;
        logic         unf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue with the effective push/pop rules.
    task automatic model(logic ps, logic [W-1:0] wd, logic pp);
        bit dp, dps;
        m_unf = pp && q.size() == 0;
        m_ovf = ps && q.size() == D && !pp;
        dp  = pp && q.size() != 0;
        dps = ps && (q.size() != D || dp);
        if (dp)  void'(q.pop_front());
        if (dps) q.push_back(wd);
    endtask

    task automatic apply(logic ps, logic [W-1:0] wd, logic pp);
        @(negedge clock);
        push  = ps;
        wdata = wd;
        pop   = pp;
        model(ps, wd, pp);
        @(posedge clock);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic chk_model(string tag);
        logic [W-1:0] er;
        er = (q.size() != 0) ? q[0] : '0;
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == D));
        chk({tag, ".rdata"}, 32'(rdata), 32'(er));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    function automatic vec_t mk(logic ps, logic pp, logic [W-1:0] wd, int c,
                                logic [W-1:0] rd, logic ovf, logic unf);
        vec_t v;
        v.push = ps; v.pop = pp; v.wdata = wd; v.cnt = c;
        v.vld = (c != 0); v.ful = (c == D); v.rd = rd;
        v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        // reset idle, fill and drain
        vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'h11, 1, 8'h11, 0, 0));
        vecs.push_back(mk(1, 0, 8'h22, 2, 8'h11, 0, 0));
        vecs.push_back(mk(1, 0, 8'h33, 3, 8'h11, 0, 0));
        vecs.push_back(mk(1, 0, 8'h44, 4, 8'h11, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 3, 8'h22, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 2, 8'h33, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 8'h44, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0));
        // refill, push+pop while full, overflow, drain
        vecs.push_back(mk(1, 0, 8'h11, 1, 8'h11, 0, 0));
        vecs.push_back(mk(1, 0, 8'h22, 2, 8'h11, 0, 0));
        vecs.push_back(mk(1, 0, 8'h33, 3, 8'h11, 0, 0));
        vecs.push_back(mk(1, 0, 8'h44, 4, 8'h11, 0, 0));
        vecs.push_back(mk(1, 1, 8'h55, 4, 8'h22, 0, 0));
        vecs.push_back(mk(1, 0, 8'h66, 4, 8'h22, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 4, 8'h22, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 3, 8'h33, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 2, 8'h44, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 8'h55, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0));
        // push+pop while empty
        vecs.push_back(mk(1, 1, 8'h77, 1, 8'h77, 0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0));

        repeat (2) @(posedge clock);
        #1;
        chk("rst.count", 32'(count), 0);
        chk("rst.valid", 32'(valid), 0);
        chk("rst.full", 32'(full), 0);
        chk("rst.rdata", 32'(rdata), 0);
        chk("rst.flags", 32'({overflow, underflow}), 0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            string n;
            v = vecs[i];
            n = $sformatf("vec%0d", i);
            apply(v.push, v.wdata, v.pop);
            chk({n, ".count"}, 32'(count), 32'(v.cnt));
            chk({n, ".valid"}, 32'(valid), 32'(v.vld));
            chk({n, ".full"}, 32'(full), 32'(v.ful));
            chk({n, ".rdata"}, 32'(rdata), 32'(v.rd));
            chk({n, ".overflow"}, 32'(overflow), 32'(v.ovf));
            chk({n, ".underflow"}, 32'(underflow), 32'(v.unf));
        end

        // wrap-around: occupancy held at 1..2, order must be 1..10
        begin
            logic [W-1:0] expv;
            apply(1, 8'h01, 0);
            chk_model("wrap0");
            expv = 8'h01;
            for (int i = 2; i <= 10; i++) begin
                apply(1, W'(i), 0);
                chk_model("wrap.push");
                chk("wrap.cnt_le2", 32'(count <= 2), 1);
                chk("wrap.head", 32'(rdata), 32'(expv));
                apply(0, 8'h00, 1);
                chk_model("wrap.pop");
                expv = W'(i);
                chk("wrap.order", 32'(rdata), 32'(expv));
            end
            apply(0, 8'h00, 1);
            chk_model("wrap.end");
        end

        // async reset between edges with three entries queued
        apply(1, 8'hC1, 0);
        apply(1, 8'hC2, 0);
        apply(1, 8'hC3, 0);
        chk_model("pre_rst");
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.valid", 32'(valid), 0);
        chk("arst.count", 32'(count), 0);
        chk("arst.rdata", 32'(rdata), 0);
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        apply(1, 8'hA5, 0);
        chk("arst.head", 32'(rdata), 32'h0A5);
        chk("arst.cnt1", 32'(count), 1);
        chk_model("post_rst");

        // random traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            logic ps, pp;
            ps = ($urandom_range(99) < ((i / 100) % 2 ? 70 : 40));
            pp = ($urandom_range(99) < ((i / 100) % 2 ? 40 : 70));
            apply(ps, W'($urandom), pp);
            chk_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
